// File: rtl/button_conditioner_if.sv
// Signal bundle between the raw push-button pins / control logic and button_conditioner.
// The slave modport is the conditioner; the master side drives the pins and the sampling tick.
`timescale 1ns/1ps
interface button_conditioner_if #(
  parameter int NUM_CH = 2
);
  logic              i_sample_en;
  logic [NUM_CH-1:0] i_btn_in;
  logic              i_toggle_clr;
  logic [NUM_CH-1:0] o_level;
  logic [NUM_CH-1:0] o_press;
  logic [NUM_CH-1:0] o_release;
  logic [NUM_CH-1:0] o_toggle;
  logic              o_any_press;

  modport master (
    output i_sample_en, i_btn_in, i_toggle_clr,
    input  o_level, o_press, o_release, o_toggle, o_any_press
  );

  modport slave (
    input  i_sample_en, i_btn_in, i_toggle_clr,
    output o_level, o_press, o_release, o_toggle, o_any_press
  );
endinterface

// File: rtl/button_conditioner.sv
// Multi-channel push-button front end: synchroniser, counter-based stability filter,
// registered press/release pulses and optional press-to-toggle latches.
`timescale 1ns/1ps
module button_conditioner #(
  parameter int                NUM_CH      = 2,
  parameter int                SYNC_STAGES = 2,
  parameter int                STABLE_CNT  = 4,
  parameter logic [NUM_CH-1:0] TOGGLE_MASK = 2'b10
) (
  input logic                  clkDis,
  input logic                  rst,
  button_conditioner_if.slave  bus
);
  localparam int CNT_W = $clog2(STABLE_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

  typedef enum logic [1:0] {
    IDLE_LO = 2'b00,
    CHK_HI  = 2'b01,
    IDLE_HI = 2'b10,
    CHK_LO  = 2'b11
  } state_t;

  logic [NUM_CH-1:0] w_level;
  logic [NUM_CH-1:0] w_press;
  logic [NUM_CH-1:0] w_release;
  logic [NUM_CH-1:0] w_toggle;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [SYNC_STAGES-1:0] r_sync;
    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic                   w_s;
    logic                   w_rise;
    logic                   w_fall;
    logic                   r_level;
    logic                   r_press;
    logic                   r_release;

    assign w_s = r_sync[SYNC_STAGES-1];

    // Synchroniser runs every clock, independent of the sampling tick
    always_ff @(posedge clkDis) begin
      if (rst) begin
        r_sync <= '0;
      end else begin
        r_sync <= {r_sync[SYNC_STAGES-2:0], bus.i_btn_in[g]};
      end
    end

    // Filter next-state: a new level must persist for STABLE_CNT enabled samples
    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_rise      = 1'b0;
      w_fall      = 1'b0;
      if (bus.i_sample_en) begin
        case (r_state)
          IDLE_LO: begin
            if (w_s) begin
              if (STABLE_CNT == 1) begin
                w_state_nxt = IDLE_HI;
                w_cnt_nxt   = '0;
                w_rise      = 1'b1;
              end else begin
                w_state_nxt = CHK_HI;
                w_cnt_nxt   = CNT_W'(1);
              end
            end else begin
              w_cnt_nxt = '0;
            end
          end
          CHK_HI: begin
            if (!w_s) begin
              w_state_nxt = IDLE_LO;
              w_cnt_nxt   = '0;
            end else if (r_cnt == CNT_LAST) begin
              w_state_nxt = IDLE_HI;
              w_cnt_nxt   = '0;
              w_rise      = 1'b1;
            end else begin
              w_cnt_nxt = r_cnt + CNT_W'(1);
            end
          end
          IDLE_HI: begin
            if (!w_s) begin
              if (STABLE_CNT == 1) begin
                w_state_nxt = IDLE_LO;
                w_cnt_nxt   = '0;
                w_fall      = 1'b1;
              end else begin
                w_state_nxt = CHK_LO;
                w_cnt_nxt   = CNT_W'(1);
              end
            end else begin
              w_cnt_nxt = '0;
            end
          end
          CHK_LO: begin
            if (w_s) begin
              w_state_nxt = IDLE_HI;
              w_cnt_nxt   = '0;
            end else if (r_cnt == CNT_LAST) begin
              w_state_nxt = IDLE_LO;
              w_cnt_nxt   = '0;
              w_fall      = 1'b1;
            end else begin
              w_cnt_nxt = r_cnt + CNT_W'(1);
            end
          end
          default: begin
            w_state_nxt = IDLE_LO;
            w_cnt_nxt   = '0;
          end
        endcase
      end else begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
      end
    end

    // Filter state plus registered level and one-cycle pulses
    always_ff @(posedge clkDis) begin
      if (rst) begin
        r_state   <= IDLE_LO;
        r_cnt     <= '0;
        r_level   <= 1'b0;
        r_press   <= 1'b0;
        r_release <= 1'b0;
      end else begin
        r_state   <= w_state_nxt;
        r_cnt     <= w_cnt_nxt;
        r_level   <= w_rise ? 1'b1 : (w_fall ? 1'b0 : r_level);
        r_press   <= w_rise;
        r_release <= w_fall;
      end
    end

    assign w_level[g]   = r_level;
    assign w_press[g]   = r_press;
    assign w_release[g] = r_release;

    if (TOGGLE_MASK[g]) begin : g_tgl
      logic r_toggle;

      // Toggle flips together with the press pulse; a coincident clear wins
      always_ff @(posedge clkDis) begin
        if (rst) begin
          r_toggle <= 1'b0;
        end else if (bus.i_toggle_clr) begin
          r_toggle <= 1'b0;
        end else begin
          r_toggle <= w_rise ? ~r_toggle : r_toggle;
        end
      end

      assign w_toggle[g] = r_toggle;
    end else begin : g_no_tgl
      assign w_toggle[g] = 1'b0;
    end
  end

  assign bus.o_level     = w_level;
  assign bus.o_press     = w_press;
  assign bus.o_release   = w_release;
  assign bus.o_toggle    = w_toggle;
  assign bus.o_any_press = |w_press;
endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Parametrised multi-channel front end for the stopwatch push-buttons (reset, pause, and future adjust/select buttons). It sits between the raw board pins and the clock/display control logic, all in the clkDis domain.
- Per channel it synchronises the raw button, applies a counter-based stability filter and tracks the debounced level.
- It emits one-cycle press and release pulses and, on selected channels, a press-to-toggle latch (pause-style behaviour), with a software clear for the latches.

Parameters:
- NUM_CH, 2, number of independent button channels (>=1)
- SYNC_STAGES, 2, flops in the input synchroniser (>=2)
- STABLE_CNT, 4, consecutive enabled samples of a new value required before it is accepted (>=1)
- TOGGLE_MASK, 2'b10, NUM_CH-bit mask; bit i=1 gives channel i a toggle latch
- CNT_W, localparam, $clog2(STABLE_CNT+1)

Ports:
- clkDis, input, 1, system clock
- rst, input, 1, reset: synchronous, active-high
- sample_en, input, 1, sampling tick; filter state advances only when high (tie high to sample every clock)
- btn_in, input, NUM_CH, raw asynchronous button levels, active-high
- toggle_clr, input, 1, synchronous clear of all toggle latches
- level, output, NUM_CH, debounced button level
- press, output, NUM_CH, one-cycle pulse on accepted rising edge
- release, output, NUM_CH, one-cycle pulse on accepted falling edge
- toggle, output, NUM_CH, toggle latch; always 0 on channels whose TOGGLE_MASK bit is 0
- any_press, output, 1, OR of press

Behaviour:
- Reset (rst=1 at a clkDis edge):
  - All synchroniser flops, counters and outputs go to 0.
  - Every channel FSM goes to IDLE_LO.
  - Reset has priority over all other inputs, including mid-filtering and mid-pulse.
- Synchroniser:
  - btn_in[i] passes through SYNC_STAGES flops, clocked every cycle regardless of sample_en. The synchronised bit is s[i].
- Per-channel FSM (states IDLE_LO, CHK_HI, IDLE_HI, CHK_LO). It evaluates only in cycles with sample_en=1 and holds state and counter otherwise.
  - IDLE_LO, s=1:
    - If STABLE_CNT=1, go to IDLE_HI (accept).
    - Otherwise go to CHK_HI with cnt=1.
  - CHK_HI, s=0: glitch. Go to IDLE_LO, cnt=0, no pulse.
  - CHK_HI, s=1, cnt<STABLE_CNT-1: cnt++.
  - CHK_HI, s=1, cnt=STABLE_CNT-1: go to IDLE_HI, cnt=0 (accept).
  - IDLE_HI and CHK_LO mirror the above with s inverted. Acceptance returns the channel to IDLE_LO.
- Outputs on accept:
  - Rising accept: level[i] goes to 1 and press[i]=1 for exactly the following clkDis cycle.
  - Falling accept: level[i] goes to 0 and release[i]=1 for exactly the following clkDis cycle.
  - Pulses are registered and deassert on the next edge even if sample_en stays high.
- Latency with sample_en tied high and a clean edge: press/level rise SYNC_STAGES+STABLE_CNT cycles after btn_in rises. Defaults: 6 cycles. Release follows the same latency.
- Glitch rejection: any excursion shorter than STABLE_CNT enabled samples produces no level change and no pulse. The counter restarts from 0 on the next excursion.
- Toggle latch (TOGGLE_MASK[i]=1):
  - toggle[i] flips in the same cycle press[i] asserts.
  - toggle_clr=1 forces all toggle bits to 0.
  - toggle_clr coincident with a press: clear wins, result 0.
  - Release never affects toggle.
- Channels are fully independent. Simultaneous presses on several channels produce simultaneous pulses; any_press is the OR of press, same cycle.
- Counter width is CNT_W. The counter never exceeds STABLE_CNT-1; there is no wrap.

Test Plan:
- Reset: drive rst=1 for 2 cycles with btn_in=2'b11 -> level, press, release, toggle and any_press all 0; after rst drops, press[1:0]=2'b11 exactly 6 cycles later.
- Clean press on ch0 (defaults, sample_en=1): btn_in[0] rises at cycle 10 and is held -> level[0]=1 and press[0] high only in cycle 16; release[0] pulses 6 cycles after btn_in[0] falls.
- Glitch: btn_in[1] high for 3 cycles, then low -> no press, level[1] stays 0, toggle[1] stays 0; a later 10-cycle hold -> one press, toggle[1]=1.
- Toggle and clear: two accepted presses on ch1 -> toggle[1] goes 1 then 0; a third press coincident with toggle_clr=1 -> toggle[1]=0; ch0 presses leave toggle[0]=0.
- sample_en=1 every 4th cycle, STABLE_CNT=4: btn_in[0] held high -> press after SYNC_STAGES plus 4 enabled samples (~16-18 cycles), pulse one cycle wide.
- Reset mid-filter: rst asserted while ch0 is in CHK_HI with cnt=2 -> no press; after release of rst the filter restarts and the full 6-cycle latency applies.
